// File: rtl/apb_pwm_pkg.sv
// Shared register map and CTRL field layout for the APB multi-channel PWM.
package apb_pwm_pkg;

  // Word offsets on PADDR[19:2]
  localparam logic [17:0] ADDR_CTRL     = 18'h00;
  localparam logic [17:0] ADDR_PRE      = 18'h01;
  localparam logic [17:0] ADDR_PERIOD   = 18'h02;
  localparam logic [17:0] ADDR_STATUS   = 18'h03;
  localparam logic [17:0] ADDR_IM       = 18'h04;
  localparam logic [17:0] ADDR_CMP_BASE = 18'h10;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_CHEN_LSB = 8;
  localparam int CTRL_POL_LSB  = 16;

  // Value returned for any word that is not mapped
  localparam logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_pwm_mc_if.sv
// APB slave bus bundle for the PWM block (word-addressed, no wait states).
interface apb_pwm_mc_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [19:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_pwm_mc_channel.sv
// One PWM channel: shadowed compare value, comparator against the shared
// counter, polarity inversion and the registered output.
module pwm_channel
  import apb_pwm_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmp_wr,
  input  logic [CW-1:0] cmp_wdata,
  input  logic          load,
  input  logic          enable,
  input  logic          pol,
  input  logic [CW-1:0] cnt,
  output logic [CW-1:0] cmp_shadow,
  output logic          pwm_out
);

  logic [CW-1:0] cmp_active;
  logic          raw_p0;
  logic          pwm_p1;

  // Bus writes land in the shadow; the comparator only sees the active copy,
  // which is refreshed at a period boundary (or continuously while stopped)
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_shadow <= '0;
      cmp_active <= '0;
    end else begin
      if (cmp_wr) cmp_shadow <= cmp_wdata;
      if (load)   cmp_active <= cmp_shadow;
    end
  end

  assign raw_p0 = enable && (cnt < cmp_active);

  // Stage p0 -> p1: output flop, one cycle behind the counter
  always_ff @(posedge clk) begin
    if (rst) pwm_p1 <= 1'b0;
    else     pwm_p1 <= raw_p0 ^ pol;
  end

  assign pwm_out = pwm_p1;

endmodule

// File: rtl/apb_pwm_mc.sv
// APB-programmable PWM with a shared prescaler/counter, NCH compare channels,
// sticky wrap status with write-1-to-clear and a maskable level interrupt.
module apb_pwm_mc #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           PCLK,
  input  logic           PRESET,
  apb_pwm_mc_if.slave    apb,
  output logic [NCH-1:0] PWM_OUT,
  output logic           IRQ
);
  import apb_pwm_pkg::*;

  logic           wr;
  logic           wr_ctrl, wr_pre, wr_period, wr_status, wr_im;
  logic [NCH-1:0] wr_cmp;

  logic           en, oneshot;
  logic [NCH-1:0] ch_en, pol;
  logic [31:0]    pre, pcnt;
  logic [CW-1:0]  period, cnt;
  logic           wrap_st, im, irq_q;

  logic           tick, wrap;
  logic           en_nxt, st_nxt, im_nxt;
  logic [31:0]    prdata;
  logic [CW-1:0]  cmp_shadow [NCH];

  assign wr        = apb.PSEL & apb.PWRITE & apb.PENABLE;
  assign wr_ctrl   = wr && (apb.PADDR == ADDR_CTRL);
  assign wr_pre    = wr && (apb.PADDR == ADDR_PRE);
  assign wr_period = wr && (apb.PADDR == ADDR_PERIOD);
  assign wr_status = wr && (apb.PADDR == ADDR_STATUS);
  assign wr_im     = wr && (apb.PADDR == ADDR_IM);

  assign tick = en && (pcnt == pre);
  // A counter above a freshly shrunk PERIOD never matches it, so the
  // natural rollover at 2^CW-1 produces no wrap event
  assign wrap = tick && (cnt == period);

  // Next-state of EN, sticky WRAP and IM; a CTRL write beats the one-shot
  // stop and a wrap beats a simultaneous clear
  always_comb begin
    en_nxt = en;
    st_nxt = wrap_st;
    im_nxt = im;
    if (wr_ctrl)               en_nxt = apb.PWDATA[CTRL_EN];
    else if (wrap && oneshot)  en_nxt = 1'b0;
    if (wrap)                          st_nxt = 1'b1;
    else if (wr_status && apb.PWDATA[0]) st_nxt = 1'b0;
    if (wr_im) im_nxt = apb.PWDATA[0];
  end

  // Register file and interrupt flop; IRQ follows the updated status/mask
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      ch_en   <= '0;
      pol     <= '0;
      pre     <= '0;
      period  <= '0;
      wrap_st <= 1'b0;
      im      <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      en      <= en_nxt;
      wrap_st <= st_nxt;
      im      <= im_nxt;
      irq_q   <= st_nxt & im_nxt;
      if (wr_ctrl) begin
        oneshot <= apb.PWDATA[CTRL_ONESHOT];
        ch_en   <= apb.PWDATA[CTRL_CHEN_LSB +: NCH];
        pol     <= apb.PWDATA[CTRL_POL_LSB +: NCH];
      end
      if (wr_pre)    pre    <= apb.PWDATA;
      if (wr_period) period <= apb.PWDATA[CW-1:0];
    end
  end

  // Prescaler and period counter, both parked at zero while stopped
  always_ff @(posedge PCLK) begin
    if (PRESET || !en) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      cnt  <= (cnt == period) ? '0 : cnt + CW'(1);
    end else begin
      pcnt <= pcnt + 32'd1;
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    assign wr_cmp[n] = wr && (apb.PADDR == ADDR_CMP_BASE + 18'(n));

    pwm_channel #(.CW(CW)) u_ch (
      .clk        (PCLK),
      .rst        (PRESET),
      .cmp_wr     (wr_cmp[n]),
      .cmp_wdata  (apb.PWDATA[CW-1:0]),
      .load       (wrap | ~en),
      .enable     (en & ch_en[n]),
      .pol        (pol[n]),
      .cnt        (cnt),
      .cmp_shadow (cmp_shadow[n]),
      .pwm_out    (PWM_OUT[n])
    );
  end

  // Side-effect-free read decode straight from PADDR
  always_comb begin
    prdata = RD_DEFAULT;
    case (apb.PADDR)
      ADDR_CTRL: begin
        prdata                         = '0;
        prdata[CTRL_EN]                = en;
        prdata[CTRL_ONESHOT]           = oneshot;
        prdata[CTRL_CHEN_LSB +: NCH]   = ch_en;
        prdata[CTRL_POL_LSB +: NCH]    = pol;
      end
      ADDR_PRE:    prdata = pre;
      ADDR_PERIOD: prdata = 32'(period);
      ADDR_STATUS: prdata = {31'd0, wrap_st};
      ADDR_IM:     prdata = {31'd0, im};
      default: begin
        for (int n = 0; n < NCH; n++) begin
          if (apb.PADDR == ADDR_CMP_BASE + 18'(n)) prdata = 32'(cmp_shadow[n]);
        end
      end
    endcase
  end

  assign apb.PRDATA = prdata;
  assign apb.PREADY = 1'b1;
  assign IRQ        = irq_q;

endmodule

// File: doc/apb_pwm_mc.md
APB_PWM_MC -- requirements
Module: apb_pwm_mc

Interface
REQ-001 Parameter NCH, 4, number of PWM channels, legal 1..8.
REQ-002 Parameter CW, 16, counter/compare width, legal 8..32.
REQ-003 PCLK  in  1  single clock; all state on rising edge.
REQ-004 PRESET  in  1  reset, synchronous, active-high.
REQ-005 PSEL, PENABLE, PWRITE  in  1 each  APB select/enable/write.
REQ-006 PADDR  in  18 ([19:2])  APB word address.
REQ-007 PWDATA  in  32  write data; PRDATA  out  32  read data.
REQ-008 PREADY  out  1  tied 1; no wait states, no error response.
REQ-009 PWM_OUT  out  NCH  per-channel PWM outputs, registered.
REQ-010 IRQ  out  1  level interrupt, registered.

Function
REQ-011 Write strobe = PSEL & PWRITE & PENABLE; reads combinational from PADDR, no side effects.
REQ-012 Word map: 0x0 CTRL, 0x1 PRE, 0x2 PERIOD, 0x3 STATUS, 0x4 IM, 0x10+n CMP[n] (n<NCH); unmapped read = 0xDEADBEEF, unmapped write ignored.
REQ-013 CTRL: bit0 EN, bit1 ONESHOT, bits[8+NCH-1:8] CH_EN, bits[16+NCH-1:16] POL; other bits read 0.
REQ-014 PRE 32-bit; PERIOD, CMP[n] CW-bit, upper bits read 0.
REQ-015 Prescaler PCNT counts 0..PRE while EN=1; tick when PCNT==PRE, then PCNT=0; PRE=0 gives tick every cycle.
REQ-016 Counter CNT increments on tick; on tick with CNT==PERIOD, CNT=0 (wrap event); PERIOD=0 means wrap every tick.
REQ-017 EN=0: PCNT and CNT held at 0; CMP active copies track shadows every cycle.
REQ-018 CMP writes go to shadow; active compare loads shadow on wrap event or while EN=0 (glitch-free update).
REQ-019 Raw[n] = EN & CH_EN[n] & (CNT < CMP_active[n]); PWM_OUT[n] = Raw[n] XOR POL[n], registered, one cycle after CNT.
REQ-020 CMP=0 -> raw constant 0; CMP>PERIOD -> raw constant 1 while enabled.
REQ-021 STATUS bit0 WRAP set on wrap event; write-1-to-clear; set wins over simultaneous clear.
REQ-022 ONESHOT=1: wrap event clears EN next cycle; an APB CTRL write in same cycle wins.
REQ-023 IM bit0 masks WRAP; IRQ = STATUS.WRAP & IM[0], registered.
REQ-024 Writing PERIOD or PRE takes effect immediately; if CNT>PERIOD after write, CNT runs to 2^CW-1, wraps to 0 naturally, no wrap event on that rollover.

Reset
REQ-025 PRESET high at any edge: CTRL, PRE, PERIOD, STATUS, IM, all CMP shadow/active, PCNT, CNT = 0.
REQ-026 During and first cycle after reset: PWM_OUT = 0, IRQ = 0; reset mid-period aborts period with no wrap event.

Structure
REQ-027 Package apb_pwm_pkg holds register word offsets, CTRL field positions, 0xDEADBEEF read default.
REQ-028 Sub-module pwm_channel (shadow/active CMP, compare, polarity, output flop) instantiated NCH times; prescaler/counter/APB in top.

Verification
REQ-029 PRE=0, PERIOD=9, CMP[0]=3, CTRL=0x101 -> PWM_OUT[0] high 3 of every 10 cycles, one cycle after CNT.
REQ-030 Mid-period write CMP[0]=7 -> duty stays 3 until wrap, then 7/10 from next period; no runt pulse.
REQ-031 POL[1]=1, CMP[1]=0, CH_EN[1]=1 -> PWM_OUT[1] constant 1; CMP[1]=20 (>PERIOD) -> constant 0.
REQ-032 ONESHOT=1, PRE=1, PERIOD=4 -> EN clears after exactly 10 cycles, one WRAP set, IRQ high with IM=1.
REQ-033 W1C STATUS in same cycle as wrap -> WRAP remains 1; next W1C clears, IRQ drops next cycle.
REQ-034 PRESET pulse mid-period -> all registers read 0, PWM_OUT=0; read 0x3F -> 0xDEADBEEF.
